// File: rtl/ce_sync_sink_if.sv
// Handshake and drain-side bundle for ce_sync_sink.
// slave is the sink's view; master is the sender/consumer view.
interface ce_sync_sink_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                     Send_in;
  logic [WIDTH-1:0]         Data_in;
  logic                     Ack_out;
  logic [WIDTH-1:0]         Dout;
  logic                     Dout_valid;
  logic                     Dout_ready;
  logic [$clog2(DEPTH):0]   Count;

  modport slave (
    input  Send_in, Data_in, Dout_ready,
    output Ack_out, Dout, Dout_valid, Count
  );

  modport master (
    output Send_in, Data_in, Dout_ready,
    input  Ack_out, Dout, Dout_valid, Count
  );
endinterface

// File: rtl/ce_sync_sink.sv
// Clocked sink for the C-element pipeline: synchronizes the active-low Send
// request, pushes bundled data into a show-ahead FIFO and withholds Ack when full.
//
// state        | meaning
// IDLE         | Ack_out high, waiting for synchronized request and FIFO space
// WAIT_RELEASE | token pushed, Ack_out low, waiting for Send_in to return high
module ce_sync_sink #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            MR_N,
  ce_sync_sink_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, WAIT_RELEASE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_req;
  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic                   push, pop, full;

  // Synchronizer idles high so a reset never looks like a request.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.Send_in};
  end

  assign s_req = sync_q[SYNC_STAGES-1];
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = (count_q != '0) && bus.Dout_ready;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!s_req && !full) begin
          push    = 1'b1;
          ack_d   = 1'b0;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (s_req) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      state_q  <= IDLE;
      ack_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.Data_in;
  end

  assign bus.Ack_out    = ack_q;
  assign bus.Dout       = mem_q[rd_ptr_q];
  assign bus.Dout_valid = (count_q != '0);
  assign bus.Count      = count_q;
endmodule

// File: tb/tb_ce_sync_sink.sv
// Self-checking bench for ce_sync_sink: scoreboard of pushed tokens compared
// against every accepted Dout, plus handshake latency and occupancy checks.
module tb_ce_sync_sink;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic MR_N;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [WIDTH-1:0] sb_q [$];
  bit   cnt_watch = 1'b0;

  ce_sync_sink_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ce_sync_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .CLK (CLK),
    .MR_N(MR_N),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: a pop is committed at the next rising edge, so compare the head now.
  always @(negedge CLK) begin
    if (MR_N && bus.Dout_valid && bus.Dout_ready) begin
      if (sb_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else                  check("dout", 64'(bus.Dout), 64'(sb_q.pop_front()));
    end
    if (cnt_watch) check("cnt_le_depth", 64'(bus.Count <= DEPTH), 64'd1);
  end

  task automatic req_start(input logic [WIDTH-1:0] d);
    bus.Data_in = d;
    bus.Send_in = 1'b0;
    sb_q.push_back(d);
  endtask

  task automatic wait_ack(input logic lvl, output int edges);
    edges = 0;
    do begin
      @(posedge CLK); #1;
      edges++;
    end while (bus.Ack_out !== lvl && edges < 100);
    if (bus.Ack_out !== lvl) check("ack_timeout", 64'(bus.Ack_out), 64'(lvl));
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int e;
    req_start(d);
    wait_ack(1'b0, e);
    bus.Send_in = 1'b1;
    wait_ack(1'b1, e);
  endtask

  task automatic drain();
    int n = 0;
    bus.Dout_ready = 1'b1;
    do begin
      @(posedge CLK); #1;
      n++;
    end while ((sb_q.size() != 0 || bus.Count != 0) && n < 200);
    bus.Dout_ready = 1'b0;
    check("drain_cnt", 64'(bus.Count), 64'd0);
    check("drain_sb", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int e;
    bit done;
    int cyc;
    MR_N = 1'b0;
    bus.Send_in = 1'b1;
    bus.Data_in = '0;
    bus.Dout_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ack", 64'(bus.Ack_out), 64'd1);
    check("rst_cnt", 64'(bus.Count), 64'd0);
    check("rst_vld", 64'(bus.Dout_valid), 64'd0);
    MR_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("post_rst_ack", 64'(bus.Ack_out), 64'd1);
    check("post_rst_vld", 64'(bus.Dout_valid), 64'd0);

    // Single token
    req_start(32'hA5A5_0001);
    wait_ack(1'b0, e);
    check("ack_fall_lat", 64'(e), 64'd3);
    check("single_cnt", 64'(bus.Count), 64'd1);
    check("single_vld", 64'(bus.Dout_valid), 64'd1);
    check("single_dout", 64'(bus.Dout), 64'hA5A5_0001);
    bus.Send_in = 1'b1;
    wait_ack(1'b1, e);
    check("ack_rise_lat", 64'(e), 64'd3);
    bus.Dout_ready = 1'b1;
    @(posedge CLK); #1;
    bus.Dout_ready = 1'b0;
    check("single_pop_cnt", 64'(bus.Count), 64'd0);
    check("single_pop_vld", 64'(bus.Dout_valid), 64'd0);

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) send(WIDTH'(i));
    check("fill_cnt", 64'(bus.Count), 64'd4);
    req_start(32'd5);
    repeat (20) @(posedge CLK);
    #1;
    check("bp_ack_held", 64'(bus.Ack_out), 64'd1);
    check("bp_cnt", 64'(bus.Count), 64'd4);
    bus.Dout_ready = 1'b1;
    @(posedge CLK); #1;
    bus.Dout_ready = 1'b0;
    check("bp_pop_ack", 64'(bus.Ack_out), 64'd1);
    check("bp_pop_cnt", 64'(bus.Count), 64'd3);
    @(posedge CLK); #1;
    check("bp_push_ack", 64'(bus.Ack_out), 64'd0);
    check("bp_push_cnt", 64'(bus.Count), 64'd4);
    bus.Send_in = 1'b1;
    wait_ack(1'b1, e);
    drain();

    // Wrap-around with Dout_ready toggling every other cycle
    cnt_watch = 1'b1;
    done = 1'b0;
    cyc = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(WIDTH'(32'h10 + i));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK); #1;
          cyc++;
          if (cyc % 2 == 0) bus.Dout_ready = ~bus.Dout_ready;
        end
      end
    join
    drain();
    cnt_watch = 1'b0;

    // Simultaneous push and pop
    send(32'h20);
    send(32'h21);
    check("pp_cnt_before", 64'(bus.Count), 64'd2);
    req_start(32'h22);
    repeat (2) @(posedge CLK);
    #1;
    bus.Dout_ready = 1'b1;
    @(posedge CLK); #1;
    bus.Dout_ready = 1'b0;
    check("pp_ack", 64'(bus.Ack_out), 64'd0);
    check("pp_cnt", 64'(bus.Count), 64'd2);
    check("pp_head", 64'(bus.Dout), 64'h21);
    bus.Send_in = 1'b1;
    wait_ack(1'b1, e);
    drain();

    // Reset mid-handshake
    send(32'h30);
    send(32'h31);
    req_start(32'h32);
    wait_ack(1'b0, e);
    check("mid_cnt", 64'(bus.Count), 64'd3);
    #1;
    MR_N = 1'b0;
    #1;
    check("mid_rst_ack", 64'(bus.Ack_out), 64'd1);
    check("mid_rst_cnt", 64'(bus.Count), 64'd0);
    check("mid_rst_vld", 64'(bus.Dout_valid), 64'd0);
    sb_q.delete();
    bus.Send_in = 1'b1;
    @(posedge CLK); #1;
    MR_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("mid_idle_ack", 64'(bus.Ack_out), 64'd1);
    check("mid_idle_cnt", 64'(bus.Count), 64'd0);
    check("mid_idle_vld", 64'(bus.Dout_valid), 64'd0);

    // Long request hold produces exactly one push
    req_start(32'h40);
    repeat (20) @(posedge CLK);
    #1;
    check("hold_ack", 64'(bus.Ack_out), 64'd0);
    check("hold_cnt", 64'(bus.Count), 64'd1);
    bus.Send_in = 1'b1;
    wait_ack(1'b1, e);
    repeat (5) @(posedge CLK);
    #1;
    check("hold_cnt_after", 64'(bus.Count), 64'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ce_sync_sink.md
# ce_sync_sink

Clocked receiver at the tail of the self-timed C-element pipeline. It accepts tokens from the last asynchronous stage over the active-low four-phase Send/Ack handshake and synchronizes the request into the clock domain. Each token's bundled data goes into a small FIFO, which the synchronous logic drains with a valid/ready interface. When the FIFO is full, the block withholds Ack_out, so the asynchronous pipeline stalls and no token is lost.

## Interface
- WIDTH, 32, bundled data width
- DEPTH, 4, FIFO entries; must be a power of two and at least 2
- SYNC_STAGES, 2, flops in the Send_in synchronizer; at least 2
- CLK  in  1  sole clock; all state updates on the rising edge
- MR_N  in  1  reset, asynchronous and active-low
- Send_in  in  1  request from the last CE stage; active low; idle high
- Data_in  in  WIDTH  bundled data; stable from Send_in falling until Ack_out falling
- Ack_out  out  1  acknowledge to the CE stage; active low; registered
- Dout  out  WIDTH  FIFO head entry (show-ahead)
- Dout_valid  out  1  FIFO not empty
- Dout_ready  in  1  consumer accepts Dout this cycle
- Count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Synchronizer:
  - Send_in passes through SYNC_STAGES flops, giving s_req.
  - All synchronizer flops reset to 1 (the idle level).
- Handshake FSM, registered, two states:
  - IDLE:
    - If s_req==0 and Count!=DEPTH: write Data_in (raw pin) at the FIFO tail, set Ack_out to 0, go to WAIT_RELEASE.
    - If s_req==0 and the FIFO is full: stay in IDLE with Ack_out=1. This is the backpressure path; the push happens on the first edge where Count<DEPTH.
  - WAIT_RELEASE:
    - If s_req==1: set Ack_out to 1 and go to IDLE.
    - Otherwise: hold.
    - A second request cannot be accepted before release, so there is exactly one push per four-phase cycle.
- FIFO:
  - Circular buffer with write and read pointers of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0.
  - Count is a separate up/down counter.
  - Pop occurs when Dout_valid && Dout_ready.
  - Push and pop on the same edge: both happen and Count is unchanged.
  - Push eligibility uses Count before the edge. A full FIFO refuses the push even if a pop happens on the same edge; the push lands one edge later.
  - Pop while empty: ignored, because Dout_valid=0.
- Dout is the combinational read of the head entry. Its value is undefined while Dout_valid=0; the bench must not check it then.
- Reset (MR_N low, at any time including mid-handshake):
  - Ack_out=1 immediately.
  - State=IDLE, Count=0, both pointers=0, Dout_valid=0, synchronizer flops=1.
  - FIFO contents are discarded.
  - If Send_in is still low after MR_N rises, that is treated as a new request. The CE stages are reset together via MR.

## Timing
- Send_in falling to Ack_out low: SYNC_STAGES+1 rising edges when the FIFO has space (3 with the default SYNC_STAGES=2).
- Send_in rising to Ack_out high: SYNC_STAGES+1 edges.
- Push edge to Dout_valid=1 when the FIFO was empty: visible right after the push edge (zero added cycles), because Dout_valid derives from registered Count.
- Sustained throughput: at best one token per 2×(SYNC_STAGES+1) clocks plus the sender's asynchronous delays.
- Bundled-data constraint on the sender: Data_in settles before Send_in falls and holds until Ack_out falls. The block samples Data_in only on the push edge.
- Outputs after reset release: Ack_out=1, Dout_valid=0, Count=0.

## Test plan
- Single token:
  - Stimulus: Data_in=0xA5A5_0001, Send_in low; release Send_in after Ack_out falls.
  - Required: Ack_out low 3 edges after Send_in falls; Count=1; Dout=0xA5A5_0001; Dout_valid=1.
  - Then with Dout_ready=1 for one cycle: Count=0.
- Fill and backpressure:
  - Stimulus: Dout_ready=0; send 5 tokens 1..5 with DEPTH=4.
  - Required: the first 4 are acknowledged and Count=4. The 5th leaves Ack_out high indefinitely.
  - Then one pop: the 5th is acknowledged one edge after the pop edge. Drain order is 1..5.
- Wrap-around:
  - Stimulus: 10 tokens 0x10..0x19 with Dout_ready toggling every other cycle.
  - Required: output order 0x10..0x19 exactly; Count never exceeds 4.
- Simultaneous push/pop:
  - Stimulus: Count=2, Dout_ready=1 on the push edge.
  - Required: Count stays 2; head advances correctly.
- Reset mid-handshake:
  - Stimulus: assert MR_N low while in WAIT_RELEASE with Count=3.
  - Required: Ack_out=1 asynchronously, before the next edge; Count=0; Dout_valid=0.
  - After release with Send_in held high: stays idle.
- Glitch-free request hold:
  - Stimulus: Send_in held low for 20 cycles.
  - Required: exactly one push; Count increments by 1 only.
